sccb_i2c_master: RTL and testbench



---
 rtl/sccb_i2c_master_pkg.sv | 22 ++
 rtl/sccb_qtr_tick.sv | 28 ++
 rtl/sccb_i2c_master.sv | 191 +++++++++++++++++++
 tb/tb_sccb_i2c_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_i2c_master_pkg.sv
// Shared definitions for the SCCB/I2C byte master: state encoding, timing helper
// and the OV7670 write address.
package sccb_i2c_master_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_START  = 4'd1,
      ST_WRITE  = 4'd2,
      ST_WR_ACK = 4'd3,
      ST_READ   = 4'd4,
      ST_RD_ACK = 4'd5,
      ST_STOP   = 4'd6
   } state_t;

   localparam logic [7:0] SCCB_WR_ADDR = 8'h42;

   // Clocks per quarter SCL period.
   function automatic int qtr_calc(input int clk_hz, input int scl_hz);
      return clk_hz / (4 * scl_hz);
   endfunction

endpackage

// File: rtl/sccb_qtr_tick.sv
// Quarter-period divider: one-clock tick every QTR enabled clocks; count is held
// at zero while disabled so the first quarter after enabling is full length.
module sccb_qtr_tick #(
   parameter int QTR = 357
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;
   localparam logic [CW-1:0] LAST = CW'(QTR - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (!en || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/sccb_i2c_master.sv
// Byte-level open-drain I2C/SCCB master: START/repeated START, byte write with
// ACK sampling, byte read with ACK/NACK, and STOP.
module sccb_i2c_master
   import sccb_i2c_master_pkg::*;
#(
   parameter int main_clock = 143_000_000,
   parameter int freq       = 100_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic [7:0] wr_data,
   output logic       rd_tick,
   output logic [1:0] ack,
   output logic [7:0] rd_data,
   inout  wire        scl,
   inout  wire        sda,
   output logic [3:0] state
);

   localparam int QTR = qtr_calc(main_clock, freq);

   state_t     state_q, state_d;
   logic [1:0] phase_q, phase_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       addr_rd_q, addr_rd_d;
   logic       sda_smp_q, sda_smp_d;
   logic       nack_q, nack_d;
   logic       tick, qtr_end, smp, ack_pulse;
   logic       scl_low, sda_low;

   sccb_qtr_tick #(.QTR(QTR)) u_qtr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state_q != ST_IDLE),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         phase_q   <= 2'd0;
         bit_q     <= 3'd0;
         shreg_q   <= 8'd0;
         rd_data_q <= 8'd0;
         addr_rd_q <= 1'b0;
         sda_smp_q <= 1'b0;
         nack_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         rd_data_q <= rd_data_d;
         addr_rd_q <= addr_rd_d;
         sda_smp_q <= sda_smp_d;
         nack_q    <= nack_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      rd_data_d = rd_data_q;
      addr_rd_d = addr_rd_q;
      sda_smp_d = sda_smp_q;
      nack_d    = nack_q;
      qtr_end   = tick && (phase_q == 2'd3);
      smp       = tick && (phase_q == 2'd2);
      ack_pulse = (state_q == ST_WR_ACK) && qtr_end;
      rd_tick   = (state_q == ST_READ) && qtr_end && (bit_q == 3'd0);
      ack       = {ack_pulse, ack_pulse & ~sda_smp_q};
      if (tick)
         phase_d = phase_q + 2'd1;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_START;
               phase_d   = 2'd0;
               shreg_d   = wr_data;
               addr_rd_d = wr_data[0];
            end
         end
         ST_START: begin
            if (qtr_end) begin
               state_d = ST_WRITE;
               bit_d   = 3'd7;
            end
         end
         ST_WRITE: begin
            if (qtr_end) begin
               if (bit_q == 3'd0) state_d = ST_WR_ACK;
               else               bit_d   = bit_q - 3'd1;
            end
         end
         ST_WR_ACK: begin
            if (smp)
               sda_smp_d = sda;
            // Caller decision cycle: stop beats start beats the address direction.
            if (qtr_end) begin
               bit_d = 3'd7;
               if (stop) begin
                  state_d = ST_STOP;
               end else if (start) begin
                  state_d   = ST_START;
                  shreg_d   = wr_data;
                  addr_rd_d = wr_data[0];
               end else if (addr_rd_q) begin
                  state_d = ST_READ;
               end else begin
                  state_d = ST_WRITE;
                  shreg_d = wr_data;
               end
            end
         end
         ST_READ: begin
            if (smp) begin
               shreg_d = {shreg_q[6:0], sda};
               if (bit_q == 3'd0)
                  rd_data_d = {shreg_q[6:0], sda};
            end
            if (qtr_end) begin
               if (bit_q == 3'd0) begin
                  state_d = ST_RD_ACK;
                  nack_d  = stop;
               end else begin
                  bit_d = bit_q - 3'd1;
               end
            end
         end
         ST_RD_ACK: begin
            if (qtr_end) begin
               if (nack_q) begin
                  state_d = ST_STOP;
               end else begin
                  state_d = ST_READ;
                  bit_d   = 3'd7;
               end
            end
         end
         ST_STOP: begin
            if (qtr_end)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Line drive decode: SCL is low in Q0 and Q3 of every data/ack bit.
   always_comb begin
      scl_low = 1'b0;
      sda_low = 1'b0;
      case (state_q)
         ST_START: begin
            sda_low = (phase_q != 2'd0);
            scl_low = (phase_q == 2'd3);
         end
         ST_WRITE: begin
            scl_low = (phase_q == 2'd0) || (phase_q == 2'd3);
            sda_low = ~shreg_q[bit_q];
         end
         ST_WR_ACK, ST_READ: begin
            scl_low = (phase_q == 2'd0) || (phase_q == 2'd3);
         end
         ST_RD_ACK: begin
            scl_low = (phase_q == 2'd0) || (phase_q == 2'd3);
            sda_low = ~nack_q;
         end
         ST_STOP: begin
            scl_low = (phase_q == 2'd0);
            sda_low = (phase_q <= 2'd1);
         end
         default: begin
            scl_low = 1'b0;
            sda_low = 1'b0;
         end
      endcase
   end

   assign scl     = scl_low ? 1'b0 : 1'bz;
   assign sda     = sda_low ? 1'b0 : 1'bz;
   assign rd_data = rd_data_q;
   assign state   = state_q;

endmodule

// File: tb/tb_sccb_i2c_master.sv
// Directed bench for sccb_i2c_master with pull-ups and a small bus-level slave.
module tb_sccb_i2c_master;
   import sccb_i2c_master_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       rd_tick;
   logic [1:0] ack;
   logic [7:0] rd_data;
   logic [3:0] state;
   wire        scl;
   wire        sda;

   int n_cmp = 0;
   int n_err = 0;

   // Bus monitor / slave model state
   logic       scl_d = 1'b1, sda_d = 1'b1;
   logic       slv_low = 1'b0;
   logic       ack_en = 1'b1;
   logic [7:0] slv_rd = 8'hA5;
   logic [7:0] cur = 8'h00;
   logic [7:0] mon_b [0:63];
   int         nb = 0, starts = 0, stops = 0, bitn = 0, rises = 0;
   logic       rd_mode = 1'b0, nacked = 1'b0, lastack = 1'b0;

   pullup (scl);
   pullup (sda);
   assign sda = slv_low ? 1'b0 : 1'bz;

   sccb_i2c_master #(.main_clock(4_000_000), .freq(100_000)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .stop    (stop),
      .wr_data (wr_data),
      .rd_tick (rd_tick),
      .ack     (ack),
      .rd_data (rd_data),
      .scl     (scl),
      .sda     (sda),
      .state   (state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (scl_d === 1'b1 && scl === 1'b1 && sda_d === 1'b1 && sda === 1'b0) begin
         starts <= starts + 1;
         bitn   <= 0;
         rises  <= 0;
         nacked <= 1'b0;
      end else if (scl_d === 1'b1 && scl === 1'b1 && sda_d === 1'b0 && sda === 1'b1) begin
         stops   <= stops + 1;
         slv_low <= 1'b0;
      end else if (scl_d !== 1'b1 && scl === 1'b1) begin
         cur <= {cur[6:0], sda};
         if (bitn == 7) begin
            mon_b[nb] <= {cur[6:0], sda};
            nb <= nb + 1;
         end
         if (bitn == 8) begin
            lastack <= sda;
            bitn <= 0;
         end else begin
            bitn <= bitn + 1;
         end
         rises <= rises + 1;
         if (rises + 1 == 8) rd_mode <= sda;
         if (rd_mode && ((rises + 1) % 9 == 0) && (rises + 1 > 9) && sda === 1'b1) nacked <= 1'b1;
      end else if (scl_d === 1'b1 && scl !== 1'b1) begin
         if ((rises % 9 == 8) && (rises < 9 || !rd_mode))
            slv_low <= ack_en;
         else if (rd_mode && rises >= 9 && (rises % 9 != 8) && !nacked)
            slv_low <= ~slv_rd[3'(7 - (rises % 9))];
         else
            slv_low <= 1'b0;
      end
      scl_d <= scl;
      sda_d <= sda;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int k);
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         start = 1'b0;
         stop  = 1'b0;
      end
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      do begin
         @(negedge clk); start = 1'b0; stop = 1'b0; n++;
      end while (ack[1] !== 1'b1 && n < 800);
   endtask

   task automatic wait_rd(output int n);
      n = 0;
      do begin
         @(negedge clk); start = 1'b0; stop = 1'b0; n++;
      end while (rd_tick !== 1'b1 && n < 800);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      do begin
         @(negedge clk); start = 1'b0; stop = 1'b0; n++;
      end while (state !== 4'd0 && n < 800);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n, b, s, t;

      // Reset state
      step(3);
      chk("rst_state", state, 4'd0);
      chk("rst_scl", scl, 1'b1);
      chk("rst_sda", sda, 1'b1);
      chk("rst_ack", ack, 2'b00);
      chk("rst_rdtick", rd_tick, 1'b0);
      chk("rst_rddata", rd_data, 8'h00);
      rst_n = 1'b1;
      step(3);

      // Write 0x42, 0x12, 0x80 with an ignored start pulse mid-byte
      b = nb; s = starts; t = stops;
      wr_data = SCCB_WR_ADDR; start = 1'b1;
      wait_ack(n);
      chk("w1_lat", n, 400);
      chk("w1_ack", ack, 2'b11);
      wr_data = 8'h12;
      step(100);
      chk("w2_busy_state", state, 4'd2);
      chk("w2_ack_idle", ack, 2'b00);
      start = 1'b1; wr_data = 8'hFF;
      step(1);
      wait_ack(n);
      chk("w2_lat", n, 259);
      chk("w2_ack", ack, 2'b11);
      wr_data = 8'h80;
      wait_ack(n);
      chk("w3_lat", n, 360);
      chk("w3_ack", ack, 2'b11);
      stop = 1'b1;
      wait_idle(n);
      chk("w_stop_lat", n, 41);
      chk("w_bus_b0", mon_b[b], 8'h42);
      chk("w_bus_b1", mon_b[b+1], 8'h12);
      chk("w_bus_b2", mon_b[b+2], 8'h80);
      chk("w_starts", starts - s, 1);
      chk("w_stops", stops - t, 1);
      chk("w_idle_scl", scl, 1'b1);
      chk("w_idle_sda", sda, 1'b1);

      // Slave NACKs; transfer continues under caller control
      step(5);
      b = nb; ack_en = 1'b0;
      wr_data = 8'h42; start = 1'b1;
      wait_ack(n);
      chk("nk1_lat", n, 400);
      chk("nk1_ack", ack, 2'b10);
      wr_data = 8'h55;
      wait_ack(n);
      chk("nk2_lat", n, 360);
      chk("nk2_ack", ack, 2'b10);
      stop = 1'b1;
      wait_idle(n);
      chk("nk_stop_lat", n, 41);
      chk("nk_bus_b1", mon_b[b+1], 8'h55);
      ack_en = 1'b1;

      // Read one byte, NACK it and stop
      step(5);
      slv_rd = 8'hA5;
      wr_data = 8'h43; start = 1'b1;
      wait_ack(n);
      chk("rd_addr_lat", n, 400);
      chk("rd_addr_ack", ack, 2'b11);
      wait_rd(n);
      chk("rd_lat", n, 320);
      chk("rd_data", rd_data, 8'hA5);
      stop = 1'b1;
      step(1);
      chk("rd_tick_single", rd_tick, 1'b0);
      wait_idle(n);
      chk("rd_stop_lat", n, 80);
      chk("rd_master_nack", lastack, 1'b1);
      chk("rd_hold", rd_data, 8'hA5);

      // Repeated start after register byte 0x0A, then read
      step(5);
      b = nb; s = starts; t = stops; slv_rd = 8'h3C;
      wr_data = 8'h42; start = 1'b1;
      wait_ack(n);
      chk("rs_addr_lat", n, 400);
      wr_data = 8'h0A;
      wait_ack(n);
      chk("rs_reg_lat", n, 360);
      chk("rs_reg_ack", ack, 2'b11);
      start = 1'b1; wr_data = 8'h43;
      step(5);
      chk("rs_q0_state", state, 4'd1);
      chk("rs_q0_scl", scl, 1'b1);
      chk("rs_q0_sda", sda, 1'b1);
      step(10);
      chk("rs_q1_scl", scl, 1'b1);
      chk("rs_q1_sda", sda, 1'b0);
      chk("rs_starts", starts - s, 2);
      chk("rs_no_stop", stops - t, 0);
      wait_ack(n);
      chk("rs_addr2_lat", n, 385);
      chk("rs_addr2_ack", ack, 2'b11);
      wait_rd(n);
      chk("rs_rd_lat", n, 320);
      chk("rs_rd_data", rd_data, 8'h3C);
      stop = 1'b1;
      step(1);
      wait_idle(n);
      chk("rs_stop_lat", n, 80);
      chk("rs_bus_b2", mon_b[b+2], 8'h43);
      chk("rs_stops", stops - t, 1);

      // Asynchronous reset during bit 4 of the address byte
      step(5);
      wr_data = 8'h42; start = 1'b1;
      step(166);
      chk("ar_pre_state", state, 4'd2);
      chk("ar_pre_scl", scl, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("ar_scl", scl, 1'b1);
      chk("ar_sda", sda, 1'b1);
      chk("ar_state", state, 4'd0);
      step(2);
      rst_n = 1'b1;
      step(2);
      wr_data = 8'h42; start = 1'b1;
      wait_ack(n);
      chk("ar_after_lat", n, 400);
      chk("ar_after_ack", ack, 2'b11);
      stop = 1'b1;
      wait_idle(n);
      chk("ar_after_stop", n, 41);
      chk("ar_after_byte", mon_b[nb-1], 8'h42);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
